// File: rtl/ctrl_protocol_pkg.sv
// ctrl_protocol_pkg: command, response, error and FSM state encodings of the host protocol
package ctrl_protocol_pkg;
  typedef enum logic [1:0] {
    CMD_SETUP_OUTPUT  = 2'd0,
    CMD_SETUP_INPUT   = 2'd1,
    CMD_STREAM_OUTPUT = 2'd2,
    CMD_STOP          = 2'd3
  } cmd_e;
  localparam logic [1:0] RSP_STOPPED = 2'd3;
  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_SETUP_LEN      = 3'd1,
    ERR_STOP_LEN       = 3'd2,
    ERR_UNSUPPORTED    = 3'd3,
    ERR_NOT_CONFIGURED = 3'd4
  } err_e;
  typedef enum logic [2:0] {ST_HDR, ST_SETUP, ST_STREAM, ST_DISCARD, ST_RESP} state_e;
endpackage

// File: rtl/ctrl_resp_writer.sv
// ctrl_resp_writer: pushes {RSP_STOPPED,1} then code while start is held; done flags the second push
module ctrl_resp_writer
  import ctrl_protocol_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CMD_W  = 2,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] code,
  input  logic              full,
  input  logic              afull,
  output logic              en,
  output logic [DATA_W-1:0] data,
  output logic              done
);
  logic idx;
  logic push;
  assign push = start && !full && !afull;
  assign done = push && idx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx  <= 1'b0;
      en   <= 1'b0;
      data <= '0;
    end else begin
      en  <= push;
      idx <= start && (idx ^ push);
      if (push) data <= idx ? code : {CMD_W'(RSP_STOPPED), LEN_W'(1)};
    end
endmodule

// File: rtl/ctrl_protocol_engine.sv
// ctrl_protocol_engine: parses header/payload bytes, applies setup, streams payload round-robin and writes STOPPED responses
module ctrl_protocol_engine
  import ctrl_protocol_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CMD_W  = 2,
  parameter int LEN_W  = 6,
  parameter int NUM_CH = 2,
  parameter int CFG_W  = 7,
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  output logic              rd_in_fifo_en_o,
  input  logic              rd_in_fifo_empty_i,
  input  logic [DATA_W-1:0] rd_in_fifo_data_i,
  output logic              wr_out_fifo_en_o,
  output logic [DATA_W-1:0] wr_out_fifo_data_o,
  input  logic              wr_out_fifo_full_i,
  input  logic              wr_out_fifo_afull_i,
  output logic [DATA_W-1:0] stream_data_o,
  output logic [CH_W-1:0]   stream_ch_o,
  output logic              stream_valid_o,
  input  logic              stream_ready_i,
  output logic [CFG_W-1:0]  cfg_o,
  output logic              cfg_valid_o,
  output logic              err_o
);
  state_e            state_q, state_d;
  err_e              code_q, code_d;
  logic [LEN_W-1:0]  cnt_q;
  logic [CH_W-1:0]   nch_q;
  logic [CMD_W-1:0]  h_cmd;
  logic [LEN_W-1:0]  h_len;
  logic              rsp, done, spop, hpop;
  assign h_cmd = rd_in_fifo_data_i[DATA_W-1:LEN_W];
  assign h_len = rd_in_fifo_data_i[LEN_W-1:0];
  // a pending stream byte blocks the next stream pop until it is handed off
  assign rd_in_fifo_en_o = !rd_in_fifo_empty_i && (state_q == ST_HDR || state_q == ST_SETUP ||
    state_q == ST_DISCARD || (state_q == ST_STREAM && (!stream_valid_o || stream_ready_i)));
  assign hpop = rd_in_fifo_en_o && state_q == ST_HDR;
  assign spop = rd_in_fifo_en_o && state_q == ST_STREAM;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    rsp     = 1'b0;
    case (state_q)
      ST_HDR: if (rd_in_fifo_en_o) begin
        if (h_cmd == CMD_W'(CMD_SETUP_OUTPUT)) begin
          if (h_len == LEN_W'(1)) state_d = ST_SETUP;
          else begin rsp = 1'b1; code_d = ERR_SETUP_LEN; end
        end else if (h_cmd == CMD_W'(CMD_SETUP_INPUT)) begin
          rsp = 1'b1; code_d = ERR_UNSUPPORTED;
        end else if (h_cmd == CMD_W'(CMD_STREAM_OUTPUT)) begin
          if (!cfg_valid_o) begin rsp = 1'b1; code_d = ERR_NOT_CONFIGURED; end
          else if (h_len != '0) state_d = ST_STREAM;
        end else begin
          rsp = 1'b1; code_d = h_len == '0 ? ERR_NONE : ERR_STOP_LEN;
        end
        if (rsp) state_d = h_len != '0 ? ST_DISCARD : ST_RESP;
      end
      ST_SETUP:   if (rd_in_fifo_en_o) state_d = ST_HDR;
      ST_STREAM:  if (rd_in_fifo_en_o && cnt_q == LEN_W'(1)) state_d = ST_HDR;
      ST_DISCARD: if (rd_in_fifo_en_o && cnt_q == LEN_W'(1)) state_d = ST_RESP;
      ST_RESP:    if (done) state_d = ST_HDR;
      default:    state_d = ST_HDR;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= ST_HDR;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      cnt_q          <= '0;
      nch_q          <= '0;
      stream_data_o  <= '0;
      stream_ch_o    <= '0;
      stream_valid_o <= 1'b0;
      cfg_o          <= '0;
      cfg_valid_o    <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      if (hpop) begin
        cnt_q <= h_len;
        nch_q <= '0;
        if (h_cmd == CMD_W'(CMD_STOP) && h_len == '0) cfg_valid_o <= 1'b0;
      end
      if (rd_in_fifo_en_o && (state_q == ST_STREAM || state_q == ST_DISCARD)) cnt_q <= cnt_q - 1'b1;
      if (rd_in_fifo_en_o && state_q == ST_SETUP) begin
        cfg_o       <= rd_in_fifo_data_i[CFG_W-1:0];
        cfg_valid_o <= 1'b1;
        err_o       <= 1'b0;
      end
      // the channel travels with its byte so a held byte keeps its destination
      if (spop) begin
        stream_data_o  <= rd_in_fifo_data_i;
        stream_valid_o <= 1'b1;
        stream_ch_o    <= nch_q;
        nch_q          <= nch_q == CH_W'(NUM_CH - 1) ? '0 : nch_q + 1'b1;
      end else if (stream_ready_i) stream_valid_o <= 1'b0;
      if (done && code_q != ERR_NONE) err_o <= 1'b1;
    end
  ctrl_resp_writer #(.DATA_W(DATA_W), .CMD_W(CMD_W), .LEN_W(LEN_W)) u_resp (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .start   (state_q == ST_RESP),
    .code    (DATA_W'(code_q)),
    .full    (wr_out_fifo_full_i),
    .afull   (wr_out_fifo_afull_i),
    .en      (wr_out_fifo_en_o),
    .data    (wr_out_fifo_data_o),
    .done    (done)
  );
endmodule

// File: tb/tb_ctrl_protocol_engine.sv
// tb_ctrl_protocol_engine: directed protocol vectors checked against a command-level model
module tb_ctrl_protocol_engine;
  localparam int NUM_CH = 2;
  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       rd_en;
  logic       empty = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full = 1'b0;
  logic       afull = 1'b0;
  logic [7:0] s_data;
  logic [0:0] s_ch;
  logic       s_valid;
  logic       s_ready = 1'b1;
  logic [6:0] cfg;
  logic       cfg_valid;
  logic       err;
  int checks = 0;
  int errors = 0;
  logic [7:0] in_mem [0:255];
  int wp = 0;
  int rp = 0;
  logic [6:0] m_cfg = 7'h00;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  logic [8:0] exp_s[$];
  logic [7:0] exp_o[$];
  logic [7:0] mq[$];
  logic       prev_block = 1'b0;

  ctrl_protocol_engine #(.NUM_CH(NUM_CH)) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .rd_in_fifo_en_o     (rd_en),
    .rd_in_fifo_empty_i  (empty),
    .rd_in_fifo_data_i   (rd_data),
    .wr_out_fifo_en_o    (wr_en),
    .wr_out_fifo_data_o  (wr_data),
    .wr_out_fifo_full_i  (full),
    .wr_out_fifo_afull_i (afull),
    .stream_data_o       (s_data),
    .stream_ch_o         (s_ch),
    .stream_valid_o      (s_valid),
    .stream_ready_i      (s_ready),
    .cfg_o               (cfg),
    .cfg_valid_o         (cfg_valid),
    .err_o               (err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // show-ahead input FIFO
  always @(posedge clk_i) begin
    if (reset_n_i && rd_en && !empty) rp = rp + 1;
    #1;
    empty = (rp == wp);
    rd_data = empty ? 8'h00 : in_mem[rp];
  end

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (s_valid && s_ready) begin
        if (exp_s.size() == 0) chk("stream_extra", {23'd0, s_ch, s_data}, 32'hFFFF_FFFF);
        else begin
          logic [8:0] e;
          e = exp_s.pop_front();
          chk("stream_data", s_data, e[7:0]);
          chk("stream_ch", s_ch, e[8]);
        end
      end
      if (wr_en) begin
        if (exp_o.size() == 0) chk("out_extra", wr_data, 32'hFFFF_FFFF);
        else chk("out_data", wr_data, exp_o.pop_front());
        chk("push_in_stall", prev_block, 0);
      end
      chk("rd_when_empty", rd_en & empty, 0);
    end
    prev_block = full | afull;
  end

  task automatic put(input logic [7:0] b);
    in_mem[wp] = b;
    wp++;
    mq.push_back(b);
  endtask

  // interprets one complete command from the queued bytes
  task automatic model_cmd();
    logic [7:0] h, p;
    int len, code;
    h = mq.pop_front();
    len = int'(h[5:0]);
    code = -1;
    case (h[7:6])
      2'd0: if (len == 1) begin
        p = mq.pop_front();
        m_cfg = p[6:0];
        m_valid = 1'b1;
        m_err = 1'b0;
      end else code = 1;
      2'd1: code = 3;
      2'd2: if (!m_valid) code = 4;
      else for (int i = 0; i < len; i++) begin
        p = mq.pop_front();
        exp_s.push_back({1'(i % NUM_CH), p});
      end
      default: begin
        code = len == 0 ? 0 : 2;
        if (len == 0) m_valid = 1'b0;
      end
    endcase
    if (code >= 0) begin
      repeat (len) void'(mq.pop_front());
      exp_o.push_back(8'hC1);
      exp_o.push_back(8'(code));
      if (code != 0) m_err = 1'b1;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while ((rp != wp || exp_s.size() != 0 || exp_o.size() != 0 || s_valid) && n < 300) begin
      cyc(1);
      n++;
    end
    cyc(3);
    chk({tag, "_timeout"}, n >= 300, 0);
    chk({tag, "_cfg"}, cfg, m_cfg);
    chk({tag, "_cfg_valid"}, cfg_valid, m_valid);
    chk({tag, "_err"}, err, m_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_s_data"}, s_data, 0);
    chk({tag, "_s_ch"}, s_ch, 0);
    chk({tag, "_s_valid"}, s_valid, 0);
    chk({tag, "_cfg"}, cfg, 0);
    chk({tag, "_cfg_valid"}, cfg_valid, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int base, n;
    #1;
    chk_reset_outputs("reset");
    cyc(2);
    reset_n_i = 1'b1;
    cyc(1);
    put(8'h01); put(8'h15); model_cmd();
    chk("model_cfg_pin", m_cfg, 7'h15);
    settle("setup");
    chk("setup_cfg_lit", cfg, 7'h15);
    put(8'h83); put(8'h10); put(8'h20); put(8'h30); model_cmd();
    chk("model_ch_pin", exp_s[1], 9'h120);
    settle("stream");
    s_ready = 1'b0;
    base = rp;
    put(8'h83); put(8'h10); put(8'h20); put(8'h30); model_cmd();
    n = 0;
    while (!s_valid && n < 20) begin cyc(1); n++; end
    chk("stall_timeout", n >= 20, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_data", s_data, 8'h10);
      chk("stall_pops", rp - base, 2);
    end
    s_ready = 1'b1;
    settle("stream_stall");
    put(8'h02); put(8'hAA); put(8'hBB); model_cmd();
    chk("model_code_pin", exp_o[1], 8'h01);
    settle("discard");
    chk("discard_err_lit", err, 1);
    afull = 1'b1;
    put(8'hC0); model_cmd();
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("afull_no_push", wr_en, 0);
    end
    afull = 1'b0;
    settle("stop");
    chk("stop_cfg_valid_lit", cfg_valid, 0);
    chk("stop_err_lit", err, 1);
    full = 1'b1;
    put(8'h40); model_cmd();
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("full_no_push", wr_en, 0);
    end
    full = 1'b0;
    settle("unsupported");
    put(8'h81); put(8'h55); model_cmd();
    settle("not_configured");
    put(8'hC1); put(8'h00); model_cmd();
    settle("stop_len");
    put(8'h01); put(8'h7F); model_cmd();
    settle("setup2");
    chk("setup2_err_lit", err, 0);
    put(8'h80); model_cmd();
    settle("stream_len0");
    put(8'h83); put(8'h10);
    mq.delete();
    exp_s.push_back(9'h010);
    n = 0;
    while (exp_s.size() != 0 && n < 20) begin cyc(1); n++; end
    chk("midreset_timeout", n >= 20, 0);
    reset_n_i = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    m_cfg = 7'h00;
    m_valid = 1'b0;
    m_err = 1'b0;
    cyc(2);
    reset_n_i = 1'b1;
    cyc(1);
    put(8'h01); put(8'h15); model_cmd();
    settle("after_reset");
    chk("after_reset_cfg_lit", cfg, 7'h15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
